lcd_slot_sched: RTL and testbench
=================================

# lcd_slot_sched

Write scheduler and character store for the 12 LCD character slots (line 0 positions 0-5, line 1 positions 0-5) driven into the LCD_TEST controller's d0x0..d1x5 inputs. Two independent requesters write single characters over a req/ack handshake and share the store under round-robin arbitration. A sequenced clear engine fills every slot with a blank character. The block sits between the top-level glue logic and LCD_TEST, and its outputs are the only drivers of the slot wires.

## Interface
- N_SLOTS, 12: number of character slots. Fixed at 12 in this revision; any other value is unsupported.
- RST_CHAR, 8'h20: value loaded into every slot on reset (ASCII space).
- CLR_CHAR, 8'h20: value written into every slot by the clear engine.

- iCLK  in  1  system clock (CLOCK_50 at top level).
- iRST_N  in  1  reset. Asynchronous, active-low.
- req_a / req_b  in  1  write request from requester A / B. Level signal, held until ack.
- addr_a / addr_b  in  4  slot index. 0-5 selects d0x0..d0x5; 6-11 selects d1x0..d1x5.
- data_a / data_b  in  8  character to write.
- ack_a / ack_b  out  1  one-cycle write-done pulse.
- clr_req  in  1  start a clear sequence. Sampled as a level.
- clr_busy  out  1  clear sequence in progress.
- bad_addr  out  1  one-cycle pulse when an acknowledged request carried addr ≥ 12.
- d0x0..d0x5, d1x0..d1x5  out  8 each  registered slot contents.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - CLEAR: sweep the slots.
- Reset state: IDLE. All slots = RST_CHAR. ack_a, ack_b, bad_addr, clr_busy = 0. Round-robin pointer favours A. Clear index = 0.
- IDLE, clr_req = 1 at an edge:
  - Go to CLEAR.
  - Clear has priority over any pending req, so no grant occurs at that edge.
- IDLE, no clr_req: eligible requesters are those with req = 1 and ack = 0.
  - A requester whose ack is currently high is ineligible, which prevents a double write from a held req.
  - One eligible requester: it is granted.
  - Both eligible: grant the one not granted most recently. After reset the first tie goes to A.
  - The pointer updates only on a grant.
- On a grant at edge k:
  - If addr < 12, the slot is written with data at edge k.
  - The granted requester's ack is high for the cycle after edge k.
  - If addr ≥ 12, no slot changes, ack still pulses, and bad_addr pulses in the same cycle as ack.
- Requester rules:
  - Keep addr/data stable while req is high and ack has not yet been seen.
  - Deassert req, or present the next transfer, after sampling ack = 1.
- CLEAR:
  - One slot per cycle, indices 0..11 in order, each written with CLR_CHAR.
  - After slot 11 is written, return to IDLE and reset the index to 0.
  - clr_req during CLEAR is ignored, and no retrigger is latched.
  - Requests are not granted during CLEAR; they stay pending and are served after the return to IDLE.
- Reset asserted at any time (mid-clear, mid-handshake): outputs go to their reset values immediately. An aborted clear is not resumed.

## Timing
- Write latency: slot visible and ack high one cycle after the granting edge.
- Throughput:
  - A single requester completes at most one write per 2 cycles (grant, ack, grant...).
  - Two contending requesters alternate and together achieve one write per cycle.
- Clear sequence, with clr_req sampled at edge k:
  - clr_busy = 1 from edge k.
  - Slot i is written at edge k+1+i.
  - At edge k+12, slot 11 is written and clr_busy drops.
  - The earliest subsequent grant is at edge k+13.
- bad_addr is coincident with the corresponding ack and lasts one cycle.
- Simultaneous clr_req and req at the same IDLE edge: clear wins, and the req is granted after the clear completes.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then a single write:
  - Stimulus: release iRST_N; all slots read 8'h20. req_a = 1, addr_a = 3, data_a = 8'h41.
  - Required: d0x3 = 8'h41 and ack_a = 1 one cycle after the granting edge.
  - Required: req_a held high afterward does not produce a second ack in the following cycle.
- Contention:
  - Stimulus: req_a and req_b held high from the same edge, addr_a = 0/data 8'h31, addr_b = 7/data 8'h32. Each requester drops req after its ack.
  - Required: A is acked first, B one cycle later, d0x0 = 8'h31, d1x1 = 8'h32.
  - Repeat with both held high: grants alternate A, B, A, B.
- Invalid address:
  - Stimulus: req_b with addr_b = 12, data 8'hFF.
  - Required: ack_b and bad_addr pulse together, and all 12 slots are unchanged.
- Clear:
  - Stimulus: fill all slots with 8'h58, then pulse clr_req at edge k, with req_a (addr 5) raised at edge k+2.
  - Required: clr_busy high for exactly 12 cycles, slots revert to 8'h20 in index order, and req_a is granted at edge k+13.
  - Required: a second clr_req during the sweep has no effect.
- Reset mid-clear:
  - Stimulus: assert iRST_N low 5 cycles into a clear.
  - Required: clr_busy = 0, acks = 0, and all slots = 8'h20 immediately.
  - Required: after release, the first tie goes to A.

Source files
------------

// File: rtl/lcd_slot_sched.sv
// Character store for the 12 LCD slots: two round-robin arbitrated single-character
// writers share the store, and a sequenced clear engine blanks every slot.
module lcd_slot_sched #(
    parameter int         N_SLOTS  = 12,
    parameter logic [7:0] RST_CHAR = 8'h20,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic       iCLK,
    input  logic       iRST_N,

    input  logic       req_a,
    input  logic [3:0] addr_a,
    input  logic [7:0] data_a,
    output logic       ack_a,

    input  logic       req_b,
    input  logic [3:0] addr_b,
    input  logic [7:0] data_b,
    output logic       ack_b,

    input  logic       clr_req,
    output logic       clr_busy,
    output logic       bad_addr,

    output logic [7:0] d0x0,
    output logic [7:0] d0x1,
    output logic [7:0] d0x2,
    output logic [7:0] d0x3,
    output logic [7:0] d0x4,
    output logic [7:0] d0x5,
    output logic [7:0] d1x0,
    output logic [7:0] d1x1,
    output logic [7:0] d1x2,
    output logic [7:0] d1x3,
    output logic [7:0] d1x4,
    output logic [7:0] d1x5
);

    localparam logic [3:0] LAST_IDX = 4'(N_SLOTS - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t     state;
    logic [7:0] slots [N_SLOTS];
    logic [3:0] clr_idx;
    logic       prio_b;     // 1: B wins the next tie (A was granted last)

    logic       elig_a;
    logic       elig_b;
    logic       grant_a;
    logic       grant_b;
    logic [3:0] win_addr;
    logic [7:0] win_data;

    // A requester still showing its ack is mid-handshake and must not be regranted.
    assign elig_a  = req_a && !ack_a;
    assign elig_b  = req_b && !ack_b;
    assign grant_a = elig_a && (!elig_b || !prio_b);
    assign grant_b = elig_b && (!elig_a ||  prio_b);

    // NOTE: every signal gets a default at the top of always_comb so no path can leave it unassigned and infer a latch.
    always_comb begin
        win_addr = addr_a;
        win_data = data_a;
        if (grant_b) begin
            win_addr = addr_b;
            win_data = data_b;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            clr_idx  <= '0;
            prio_b   <= 1'b0;
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            bad_addr <= 1'b0;
            clr_busy <= 1'b0;
            // NOTE: the store is a handful of flops driving the display, so it takes a defined reset value; a RAM-backed store would not.
            for (int i = 0; i < N_SLOTS; i++) begin
                slots[i] <= RST_CHAR;
            end
        end else begin
            ack_a    <= 1'b0;
            ack_b    <= 1'b0;
            bad_addr <= 1'b0;

            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                        clr_idx  <= '0;
                    end else if (grant_a || grant_b) begin
                        ack_a  <= grant_a;
                        ack_b  <= grant_b;
                        prio_b <= grant_a;
                        if (win_addr <= LAST_IDX) begin
                            slots[win_addr] <= win_data;
                        end else begin
                            bad_addr <= 1'b1;
                        end
                    end
                end

                CLEAR: begin
                    slots[clr_idx] <= CLR_CHAR;
                    if (clr_idx == LAST_IDX) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                        clr_idx  <= '0;
                    end else begin
                        clr_idx <= clr_idx + 4'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign d0x0 = slots[0];
    assign d0x1 = slots[1];
    assign d0x2 = slots[2];
    assign d0x3 = slots[3];
    assign d0x4 = slots[4];
    assign d0x5 = slots[5];
    assign d1x0 = slots[6];
    assign d1x1 = slots[7];
    assign d1x2 = slots[8];
    assign d1x3 = slots[9];
    assign d1x4 = slots[10];
    assign d1x5 = slots[11];

endmodule

// File: tb/tb_lcd_slot_sched.sv
// Directed bench for lcd_slot_sched: inputs change and outputs are sampled on the
// falling edge; expected slot contents come from a local shadow array.
module tb_lcd_slot_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b, clr_req;
    logic [3:0] addr_a, addr_b;
    logic [7:0] data_a, data_b;
    logic       ack_a, ack_b, clr_busy, bad_addr;
    wire  [7:0] d [0:11];

    logic [7:0] exp_s [12];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    lcd_slot_sched dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .req_a    (req_a),
        .addr_a   (addr_a),
        .data_a   (data_a),
        .ack_a    (ack_a),
        .req_b    (req_b),
        .addr_b   (addr_b),
        .data_b   (data_b),
        .ack_b    (ack_b),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .bad_addr (bad_addr),
        .d0x0     (d[0]),
        .d0x1     (d[1]),
        .d0x2     (d[2]),
        .d0x3     (d[3]),
        .d0x4     (d[4]),
        .d0x5     (d[5]),
        .d1x0     (d[6]),
        .d1x1     (d[7]),
        .d1x2     (d[8]),
        .d1x3     (d[9]),
        .d1x4     (d[10]),
        .d1x5     (d[11])
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_slots(input string tag);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_d%0d", tag, i), d[i], exp_s[i]);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        clr_req = 1'b0;
        addr_a  = '0;
        addr_b  = '0;
        data_a  = '0;
        data_b  = '0;
        for (int i = 0; i < 12; i++) exp_s[i] = 8'h20;

        // Reset state
        step();
        step();
        check("rst_ack_a", 8'(ack_a), 8'd0);
        check("rst_ack_b", 8'(ack_b), 8'd0);
        check("rst_busy", 8'(clr_busy), 8'd0);
        check("rst_bad", 8'(bad_addr), 8'd0);
        check_slots("rst");
        rst_n = 1'b1;

        // Single write from A, then req held to prove there is no double ack
        req_a  = 1'b1;
        addr_a = 4'd3;
        data_a = 8'h41;
        step();
        exp_s[3] = 8'h41;
        check("w1_ack_a", 8'(ack_a), 8'd1);
        check("w1_ack_b", 8'(ack_b), 8'd0);
        check("w1_d3", d[3], 8'h41);
        step();
        check("w1_no_double", 8'(ack_a), 8'd0);
        req_a = 1'b0;

        // Invalid address from B
        req_b  = 1'b1;
        addr_b = 4'd12;
        data_b = 8'hFF;
        step();
        check("bad_ack_b", 8'(ack_b), 8'd1);
        check("bad_pulse", 8'(bad_addr), 8'd1);
        check_slots("bad");
        req_b = 1'b0;
        step();
        check("bad_drop", 8'(bad_addr), 8'd0);
        check("bad_ack_drop", 8'(ack_b), 8'd0);

        // Contention, B was granted last so A wins the tie
        req_a  = 1'b1; addr_a = 4'd0; data_a = 8'h31;
        req_b  = 1'b1; addr_b = 4'd7; data_b = 8'h32;
        step();
        exp_s[0] = 8'h31;
        check("con_a_ack_a", 8'(ack_a), 8'd1);
        check("con_a_ack_b", 8'(ack_b), 8'd0);
        check("con_d0", d[0], 8'h31);
        req_a = 1'b0;
        step();
        exp_s[7] = 8'h32;
        check("con_b_ack_a", 8'(ack_a), 8'd0);
        check("con_b_ack_b", 8'(ack_b), 8'd1);
        check("con_d7", d[7], 8'h32);
        req_b = 1'b0;
        step();

        // Both held: grants alternate A, B, A, B
        req_a = 1'b1; addr_a = 4'd1; data_a = 8'h61;
        req_b = 1'b1; addr_b = 4'd8; data_b = 8'h62;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("alt%0d_ack_a", i), 8'(ack_a), (i % 2 == 0) ? 8'd1 : 8'd0);
            check($sformatf("alt%0d_ack_b", i), 8'(ack_b), (i % 2 == 0) ? 8'd0 : 8'd1);
            if (i % 2 == 0) begin
                exp_s[1] = data_a;
                data_a   = data_a + 8'd2;
            end else begin
                exp_s[8] = data_b;
                data_b   = data_b + 8'd2;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        step();
        check_slots("alt");

        // Fill every slot with 'X'
        for (int i = 0; i < 12; i++) begin
            req_a  = 1'b1;
            addr_a = 4'(i);
            data_a = 8'h58;
            step();
            check($sformatf("fill%0d_ack", i), 8'(ack_a), 8'd1);
            req_a    = 1'b0;
            exp_s[i] = 8'h58;
            step();
        end
        check_slots("fill");

        // Clear at edge k, req_a raised for edge k+2, a second clr_req mid-sweep
        clr_req = 1'b1;
        step();
        check("clr_busy_k", 8'(clr_busy), 8'd1);
        clr_req = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            step();
            check($sformatf("clr%0d_busy", j), 8'(clr_busy), (j < 12) ? 8'd1 : 8'd0);
            check($sformatf("clr%0d_ack_a", j), 8'(ack_a), 8'd0);
            check($sformatf("clr%0d_done", j), d[j-1], 8'h20);
            if (j < 12) check($sformatf("clr%0d_next", j), d[j], 8'h58);
            if (j == 1) begin
                req_a  = 1'b1;
                addr_a = 4'd5;
                data_a = 8'h5A;
            end
            clr_req = (j == 3);
        end
        for (int i = 0; i < 12; i++) exp_s[i] = 8'h20;
        step();
        exp_s[5] = 8'h5A;
        check("clr_grant_ack", 8'(ack_a), 8'd1);
        check("clr_grant_busy", 8'(clr_busy), 8'd0);
        check("clr_grant_d5", d[5], 8'h5A);
        req_a = 1'b0;
        step();
        check("clr_no_retrig", 8'(clr_busy), 8'd0);
        check_slots("clr");

        // Reset five cycles into a clear; A was granted last before it
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (5) step();
        check("mid_busy", 8'(clr_busy), 8'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) exp_s[i] = 8'h20;
        check("mid_rst_busy", 8'(clr_busy), 8'd0);
        check("mid_rst_ack_a", 8'(ack_a), 8'd0);
        check("mid_rst_ack_b", 8'(ack_b), 8'd0);
        check_slots("mid_rst");
        step();
        rst_n = 1'b1;
        req_a = 1'b1; addr_a = 4'd2; data_a = 8'h41;
        req_b = 1'b1; addr_b = 4'd9; data_b = 8'h42;
        step();
        check("post_rst_ack_a", 8'(ack_a), 8'd1);
        check("post_rst_ack_b", 8'(ack_b), 8'd0);
        check("post_rst_busy", 8'(clr_busy), 8'd0);
        req_a = 1'b0;
        step();
        check("post_rst2_ack_a", 8'(ack_a), 8'd0);
        check("post_rst2_ack_b", 8'(ack_b), 8'd1);
        req_b = 1'b0;
        exp_s[2] = 8'h41;
        exp_s[9] = 8'h42;
        step();
        check_slots("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
